// File: rtl/npu_pkg.sv
// Shared types and constants for the NPU memory loader slice.
package npu_pkg;

  localparam int DW      = 8;
  localparam int IMG_AW  = 10;
  localparam int PAR_AW  = 15;
  localparam int LEN_W   = 17;
  localparam int EW      = PAR_AW + 2;
  localparam int IMG_CAP = 4 * (2 ** IMG_AW);
  localparam int PAR_CAP = 2 ** PAR_AW;

  typedef enum logic [1:0] {
    TGT_IMAGE  = 2'd0,
    TGT_CONV   = 2'd1,
    TGT_DENSE  = 2'd2,
    TGT_DENSEB = 2'd3
  } tgt_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FIN  = 2'd2
  } ld_state_e;

  // One-hot write enable for the image bank selected by the low address bits.
  function automatic logic [3:0] bank_onehot(input logic [1:0] bank);
    bank_onehot = 4'b0001 << bank;
  endfunction

endpackage

// File: rtl/npu_mem_loader_if.sv
// Job control, byte stream and status handshake between host side and loader.
interface npu_mem_loader_if;
  import npu_pkg::*;

  logic              start;
  logic [1:0]        target;
  logic [PAR_AW-1:0] base_addr;
  logic [LEN_W-1:0]  length;
  logic              abort;
  logic              in_valid;
  logic [DW-1:0]     in_data;
  logic              in_ready;
  logic              busy;
  logic              done;
  logic              overflow;

  modport master (
    output start, target, base_addr, length, abort, in_valid, in_data,
    input  in_ready, busy, done, overflow
  );

  modport slave (
    input  start, target, base_addr, length, abort, in_valid, in_data,
    output in_ready, busy, done, overflow
  );
endinterface

// File: rtl/npu_loader_addrgen.sv
// Byte counter and effective-address generator for the loader.
// The effective address is kept at PAR_AW+2 bits; wrapping is implicit in
// the bit slices handed out, and ovf flags any address past region depth.
module npu_loader_addrgen
  import npu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              inc,
  input  tgt_e              tgt,
  input  logic [PAR_AW-1:0] base,
  output logic [LEN_W-1:0]  cnt,
  output logic [1:0]        bank,
  output logic [IMG_AW-1:0] img_addr,
  output logic [PAR_AW-1:0] par_addr,
  output logic              ovf
);

  logic [LEN_W-1:0] cnt_r;
  logic [EW-1:0]    eff_s;

  // Byte counter: cleared on an accepted start, stepped per accepted byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= {LEN_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {LEN_W{1'b0}};
    end else if (inc) begin
      cnt_r <= cnt_r + LEN_W'(1'b1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Effective address, bank split and region-depth check.
  always_comb begin
    eff_s    = {2'b00, base} + EW'(cnt_r);
    bank     = eff_s[1:0];
    img_addr = eff_s[IMG_AW+1:2];
    par_addr = eff_s[PAR_AW-1:0];
    if (tgt == TGT_IMAGE) begin
      ovf = |eff_s[EW-1:IMG_AW+2];
    end else begin
      ovf = |eff_s[EW-1:PAR_AW];
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/npu_mem_loader.sv
// Host byte stream to RAM write-port converter for the NPU memory block.
// One job loads one region; writes come out one cycle after each accept.
module npu_mem_loader
  import npu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  npu_mem_loader_if.slave   ld,
  output logic [IMG_AW-1:0] image_ram_addr_a,
  output logic [DW-1:0]     data_image0,
  output logic [DW-1:0]     data_image1,
  output logic [DW-1:0]     data_image2,
  output logic [DW-1:0]     data_image3,
  output logic              we_image0,
  output logic              we_image1,
  output logic              we_image2,
  output logic              we_image3,
  output logic [PAR_AW-1:0] conv_ram_addr_a,
  output logic [PAR_AW-1:0] dense_ram_addr_a,
  output logic [PAR_AW-1:0] denseb_ram_addr_a,
  output logic [DW-1:0]     data_conv,
  output logic [DW-1:0]     data_dense,
  output logic [DW-1:0]     data_denseb,
  output logic              we_conv,
  output logic              we_dense,
  output logic              we_denseb
);

  ld_state_e         state_r, next_state_s;
  tgt_e              tgt_r;
  logic [PAR_AW-1:0] base_r;
  logic [LEN_W-1:0]  len_r;
  logic              in_ready_r, busy_r, done_r, overflow_r;
  logic [3:0]        we_img_r;
  logic              we_conv_r, we_dense_r, we_denseb_r;
  logic [IMG_AW-1:0] img_addr_r;
  logic [PAR_AW-1:0] par_addr_r;
  logic [DW-1:0]     data_r;

  logic              start_ok_s, accept_s, last_s;
  logic [LEN_W-1:0]  cnt_s;
  logic [1:0]        bank_s;
  logic [IMG_AW-1:0] img_addr_s;
  logic [PAR_AW-1:0] par_addr_s;
  logic              ovf_s;

  // abort outranks start, even in IDLE
  assign start_ok_s = (state_r == ST_IDLE) && ld.start && !ld.abort;
  // in_ready_r is high exactly while in LOAD
  assign accept_s   = ld.in_valid && in_ready_r;
  assign last_s     = (cnt_s == (len_r - LEN_W'(1'b1)));

  npu_loader_addrgen u_addrgen (
    .clk      (clk),
    .reset    (reset),
    .clr      (start_ok_s),
    .inc      (accept_s),
    .tgt      (tgt_r),
    .base     (base_r),
    .cnt      (cnt_s),
    .bank     (bank_s),
    .img_addr (img_addr_s),
    .par_addr (par_addr_s),
    .ovf      (ovf_s)
  );

  // Next-state logic for the IDLE/LOAD/FIN job sequencer.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_ok_s) begin
          if (ld.length == {LEN_W{1'b0}}) begin
            next_state_s = ST_FIN;
          end else begin
            next_state_s = ST_LOAD;
          end
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (ld.abort) begin
          next_state_s = ST_IDLE;
        end else if (accept_s && last_s) begin
          next_state_s = ST_FIN;
        end else begin
          next_state_s = ST_LOAD;
        end
      end
      ST_FIN:  next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // State register with status flags decoded from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      in_ready_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= next_state_s;
      in_ready_r <= (next_state_s == ST_LOAD);
      busy_r     <= (next_state_s != ST_IDLE);
      done_r     <= (next_state_s == ST_FIN);
    end
  end

  // Job parameters latched on start; sticky overflow cleared by a new job.
  always_ff @(posedge clk) begin
    if (reset) begin
      tgt_r      <= TGT_IMAGE;
      base_r     <= {PAR_AW{1'b0}};
      len_r      <= {LEN_W{1'b0}};
      overflow_r <= 1'b0;
    end else if (start_ok_s) begin
      tgt_r      <= tgt_e'(ld.target);
      base_r     <= ld.base_addr;
      len_r      <= ld.length;
      overflow_r <= 1'b0;
    end else if (accept_s && ovf_s) begin
      overflow_r <= 1'b1;
    end else begin
      overflow_r <= overflow_r;
    end
  end

  // Write register: one strobe per accepted byte, address/data held between.
  always_ff @(posedge clk) begin
    if (reset) begin
      we_img_r    <= 4'b0000;
      we_conv_r   <= 1'b0;
      we_dense_r  <= 1'b0;
      we_denseb_r <= 1'b0;
      img_addr_r  <= {IMG_AW{1'b0}};
      par_addr_r  <= {PAR_AW{1'b0}};
      data_r      <= {DW{1'b0}};
    end else begin
      we_img_r    <= 4'b0000;
      we_conv_r   <= 1'b0;
      we_dense_r  <= 1'b0;
      we_denseb_r <= 1'b0;
      if (accept_s) begin
        data_r <= ld.in_data;
        case (tgt_r)
          TGT_IMAGE: begin
            img_addr_r <= img_addr_s;
            we_img_r   <= bank_onehot(bank_s);
          end
          TGT_CONV: begin
            par_addr_r <= par_addr_s;
            we_conv_r  <= 1'b1;
          end
          TGT_DENSE: begin
            par_addr_r <= par_addr_s;
            we_dense_r <= 1'b1;
          end
          TGT_DENSEB: begin
            par_addr_r  <= par_addr_s;
            we_denseb_r <= 1'b1;
          end
          default: begin
            we_img_r <= 4'b0000;
          end
        endcase
      end
    end
  end

  assign ld.in_ready = in_ready_r;
  assign ld.busy     = busy_r;
  assign ld.done     = done_r;
  assign ld.overflow = overflow_r;

  assign image_ram_addr_a  = img_addr_r;
  assign data_image0       = data_r;
  assign data_image1       = data_r;
  assign data_image2       = data_r;
  assign data_image3       = data_r;
  assign we_image0         = we_img_r[0];
  assign we_image1         = we_img_r[1];
  assign we_image2         = we_img_r[2];
  assign we_image3         = we_img_r[3];
  assign conv_ram_addr_a   = par_addr_r;
  assign dense_ram_addr_a  = par_addr_r;
  assign denseb_ram_addr_a = par_addr_r;
  assign data_conv         = data_r;
  assign data_dense        = data_r;
  assign data_denseb       = data_r;
  assign we_conv           = we_conv_r;
  assign we_dense          = we_dense_r;
  assign we_denseb         = we_denseb_r;

endmodule

// File: doc/npu_mem_loader.md
Name: npu_mem_loader

Overview:
- Write-side initiator for the NPU memory block: converts a host byte stream into RAM write strobes for the image, conv, dense and dense-bias RAMs.
- Drives the four image banks (byte-interleaved), the conv parameter RAM, the dense RAM and the dense-bias RAM through their "a" (write) ports.
- Sits between the host-bus register interface and the memory block; one load job targets one region.

Parameters:
- DW, 8, data byte width
- IMG_AW, 10, image bank address width
- PAR_AW, 15, conv/dense/denseb address width
- LEN_W, 17, job length width in bytes

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle job request; honoured only in IDLE
- target  in  2  0=image, 1=conv, 2=dense, 3=denseb; latched on start
- base_addr  in  PAR_AW  first byte address; latched on start
- length  in  LEN_W  byte count; latched on start
- abort  in  1  cancel current job
- in_valid  in  1  stream byte valid
- in_data  in  DW  stream byte
- in_ready  out  1  loader accepts byte
- busy  out  1  job active
- done  out  1  one-cycle completion pulse
- overflow  out  1  sticky: job addressed past region depth
- image_ram_addr_a  out  IMG_AW  image write address, shared by all banks
- data_image0..data_image3  out  DW each  image bank write data
- we_image0..we_image3  out  1 each  image bank write enable
- conv_ram_addr_a, dense_ram_addr_a, denseb_ram_addr_a  out  PAR_AW each  write addresses
- data_conv, data_dense, data_denseb  out  DW each  write data
- we_conv, we_dense, we_denseb  out  1 each  write enables

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: FSM in IDLE; all we_* = 0; all addresses and data = 0; in_ready = 0, busy = 0, done = 0, overflow = 0.
- FSM has three states: IDLE, LOAD, FIN.
  - IDLE: start=1 latches target, base_addr and length, and sets the byte counter cnt=0. If length == 0, go to FIN; otherwise go to LOAD.
  - LOAD: in_ready = 1. A byte is accepted when in_valid && in_ready. When the accepted byte has cnt == length-1, go to FIN.
  - FIN: done = 1 for exactly one cycle, then IDLE.
- busy = 1 in LOAD and FIN.
- abort in LOAD or FIN forces IDLE on the next edge: no done pulse, and any accepted byte still in the write register completes.
- abort has priority over start in the same cycle.
- start outside IDLE is ignored.
- Write timing: registered outputs, latency 1. A byte accepted at edge N produces exactly one we_* pulse during cycle N+1, with matching addr and data. Back-to-back bytes give back-to-back writes with no stall. in_ready does not depend on RAM state.
- Address generation: effective byte address e = base_addr + cnt, computed at PAR_AW+2 bits.
- Image target:
  - bank = e[1:0], image_ram_addr_a = e[IMG_AW+1:2].
  - Only we_image[bank] asserts.
  - All four data_imageK carry the byte.
  - Image capacity is 4*2^IMG_AW bytes.
- Other targets:
  - Address = e[PAR_AW-1:0]; only the selected we_* asserts.
  - Capacity is 2^PAR_AW bytes.
- Overflow: if e >= capacity for any accepted byte, the address wraps modulo capacity and overflow sets.
  - overflow is sticky until the next accepted start or reset.
- Simultaneous events:
  - in_valid in IDLE or FIN is not accepted (in_ready = 0).
  - start and the final byte cannot coincide, since start is only honoured in IDLE.
- Reset mid-job: all we_* are deasserted on the next edge, the job is discarded, and no done pulse is produced.
- cnt is LEN_W bits wide; a length of 2^LEN_W - 1 is legal.

Decomposition:
- Shared package npu_pkg holds:
  - typedef tgt_e {TGT_IMAGE, TGT_CONV, TGT_DENSE, TGT_DENSEB};
  - loader FSM state enum;
  - constants IMG_AW, PAR_AW, DW, IMG_CAP, PAR_CAP.
- One natural sub-module, npu_loader_addrgen: holds cnt, computes e, bank, the wrapped address and the overflow condition.
- The top module keeps the FSM and the output registers.

Test Plan:
- Image job, target=0, base=0, length=8, bytes 0x10..0x17 continuous.
  - Bank k receives bytes 0x10+k at addr 0 and 0x14+k at addr 1.
  - Exactly 8 write pulses, first one cycle after the first accept.
  - done pulses the cycle after the last accept.
- Conv job, base=0x7FFE, length=4, with in_valid gaps.
  - Writes land at 0x7FFE, 0x7FFF, 0x0000, 0x0001.
  - overflow=1 after the third accept; no writes during gaps.
- Dense and denseb jobs run back to back, length=3 each.
  - Only we_dense pulses in job 1 and only we_denseb in job 2.
  - A start pulsed during job 1 is ignored.
- length=0 start → FIN → done one cycle later; zero writes; in_ready never high.
- Cancel cases, conv length=10:
  - abort after 5 accepts: 5 writes, no done, busy=0 next cycle.
  - Repeat with reset after 5 accepts: all outputs at reset values on the next cycle.
